// File: rtl/tile_gfx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tile_gfx_pkg
// Brief    : Shared tile colour tables, decimal digit table and digit count.
// Revision : 1.0
// ============================================================================
package tile_gfx_pkg;

    typedef logic [11:0] rgb444_t;

    localparam logic [3:0] c_GLYPH_BLANK = 4'hF;
    localparam rgb444_t    c_FONT_DARK   = 12'h766;
    localparam rgb444_t    c_FONT_LIGHT  = 12'hFFF;

    function automatic rgb444_t bg_color(input logic [3:0] st);
        case (st)
            4'd0:    return 12'h000;
            4'd1:    return 12'hEED;
            4'd2:    return 12'hEEC;
            4'd3:    return 12'hFB7;
            4'd4:    return 12'hF96;
            4'd5:    return 12'hF75;
            4'd6:    return 12'hF53;
            4'd7:    return 12'hED7;
            4'd8:    return 12'hEC6;
            4'd9:    return 12'hEC5;
            4'd10:   return 12'hEC3;
            4'd11:   return 12'hEC2;
            4'd12:   return 12'hEC1;
            default: return 12'h333;
        endcase
    endfunction

    function automatic rgb444_t font_color(input logic [3:0] st);
        return (st == 4'd1 || st == 4'd2) ? c_FONT_DARK : c_FONT_LIGHT;
    endfunction

    function automatic logic [2:0] digit_count(input logic [3:0] st);
        if (st >= 4'd1 && st <= 4'd3)       return 3'd1;
        else if (st >= 4'd4 && st <= 4'd6)  return 3'd2;
        else if (st >= 4'd7 && st <= 4'd9)  return 3'd3;
        else if (st >= 4'd10 && st <= 4'd12) return 3'd4;
        else                                return 3'd0;
    endfunction

    // Decimal digits of 2^st, leftmost digit in the top nibble, blank-padded.
    function automatic logic [15:0] state_digits(input logic [3:0] st);
        case (st)
            4'd1:    return 16'h2FFF;
            4'd2:    return 16'h4FFF;
            4'd3:    return 16'h8FFF;
            4'd4:    return 16'h16FF;
            4'd5:    return 16'h32FF;
            4'd6:    return 16'h64FF;
            4'd7:    return 16'h128F;
            4'd8:    return 16'h256F;
            4'd9:    return 16'h512F;
            4'd10:   return 16'h1024;
            4'd11:   return 16'h2048;
            4'd12:   return 16'h4096;
            default: return 16'hFFFF;
        endcase
    endfunction

    function automatic logic [3:0] state_glyph(input logic [3:0] st, input logic [1:0] idx);
        logic [15:0] d;
        d = state_digits(st);
        case (idx)
            2'd0:    return d[15:12];
            2'd1:    return d[11:8];
            2'd2:    return d[7:4];
            default: return d[3:0];
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/tile_glyph_renderer_font_rom.sv
`default_nettype none
// ============================================================================
// Module   : font_rom
// Brief    : Seven-segment style digit font, one registered row per read.
// Revision : 1.0
// ============================================================================
module font_rom #(
    parameter int GLYPH_W = 16,
    parameter int GLYPH_H = 46,
    parameter int ROW_W   = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         digit,
    input  logic [ROW_W-1:0]   row,
    output logic [GLYPH_W-1:0] bits
);

    localparam int c_T   = (GLYPH_W >= 8) ? GLYPH_W / 4 : 1;
    localparam int c_MID = GLYPH_H / 2;

    // Segment order {a,b,c,d,e,f,g}; anything outside 0-9 draws nothing.
    function automatic logic [6:0] segs(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1111110;
            4'd1:    return 7'b0110000;
            4'd2:    return 7'b1101101;
            4'd3:    return 7'b1111001;
            4'd4:    return 7'b0110011;
            4'd5:    return 7'b1011011;
            4'd6:    return 7'b1011111;
            4'd7:    return 7'b1110000;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    int                 w_r;
    logic [6:0]         w_seg;
    logic               w_top, w_mid, w_bot, w_up, w_lo;
    logic [GLYPH_W-1:0] w_bits;
    logic [GLYPH_W-1:0] r_bits;

    assign w_r   = int'(row);
    assign w_seg = segs(digit);
    assign w_top = (w_r >= 1) && (w_r < 1 + c_T);
    assign w_mid = (w_r >= c_MID - c_T / 2) && (w_r < c_MID + c_T / 2);
    assign w_bot = (w_r >= GLYPH_H - 1 - c_T) && (w_r < GLYPH_H - 1);
    assign w_up  = (w_r >= 1) && (w_r < c_MID);
    assign w_lo  = (w_r >= c_MID) && (w_r < GLYPH_H - 1);

    always_comb begin
        w_bits = '0;
        for (int c = 0; c < GLYPH_W; c++) begin
            w_bits[GLYPH_W-1-c] =
                ((c >= 1) && (c < GLYPH_W - 1) &&
                    ((w_seg[6] && w_top) || (w_seg[3] && w_bot) || (w_seg[0] && w_mid))) ||
                ((c >= GLYPH_W - 1 - c_T) && (c < GLYPH_W - 1) &&
                    ((w_seg[5] && w_up) || (w_seg[4] && w_lo))) ||
                ((c >= 1) && (c < 1 + c_T) &&
                    ((w_seg[1] && w_up) || (w_seg[2] && w_lo)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_bits <= '0;
        else     r_bits <= w_bits;
    end

    assign bits = r_bits;

endmodule
`default_nettype wire

// File: rtl/tile_glyph_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tile_glyph_renderer
// Brief    : Renders one game tile (background + centred decimal value) into
//            an RGB444 pixel stream with a 3-clock pipeline and pop highlight.
// Revision : 1.0
// ============================================================================
module tile_glyph_renderer
    import tile_gfx_pkg::*;
#(
    parameter int          TILE_X0    = 0,
    parameter int          TILE_Y0    = 0,
    parameter int          TILE_SIZE  = 128,
    parameter int          GLYPH_W    = 16,
    parameter int          GLYPH_H    = 46,
    parameter int          MAX_DIGITS = 4,
    parameter int          POP_FRAMES = 8,
    parameter logic [11:0] POP_COLOR  = 12'hFFE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic [3:0]  state,
    input  logic [11:0] h_cnt,
    input  logic [11:0] v_cnt,
    output logic [11:0] vga_data,
    output logic        in_tile
);

    localparam int c_COL_W   = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
    localparam int c_ROW_W   = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
    localparam int c_POP_W   = (POP_FRAMES > 0) ? $clog2(POP_FRAMES + 1) : 1;
    localparam int c_TEXT_Y0 = (TILE_SIZE - GLYPH_H) / 2;
    localparam logic [c_POP_W-1:0] c_POP_LOAD = c_POP_W'(POP_FRAMES);

    // Frame-stable display state and pop countdown
    logic [3:0]         r_disp_state;
    logic [c_POP_W-1:0] r_pop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_disp_state <= '0;
            r_pop_cnt    <= '0;
        end else if (frame_start) begin
            r_disp_state <= state;
            if (state == 4'd0)
                r_pop_cnt <= '0;
            else if (state != r_disp_state)
                r_pop_cnt <= c_POP_LOAD;
            else if (r_pop_cnt != '0)
                r_pop_cnt <= r_pop_cnt - 1'b1;
        end
    end

    // Stage 1: coordinate decode (13-bit math keeps tile bounds from wrapping)
    logic [12:0]        w_hx, w_ly, w_text_w, w_text_x0, w_tx, w_ty;
    logic [2:0]         w_n_raw, w_n;
    logic               w_in_tile, w_in_text;
    logic [1:0]         w_dig_idx;
    logic [c_COL_W-1:0] w_col;
    logic [3:0]         w_glyph;
    rgb444_t            w_bg;

    assign w_hx      = {1'b0, h_cnt} - 13'(TILE_X0);
    assign w_ly      = {1'b0, v_cnt} - 13'(TILE_Y0);
    assign w_in_tile = ({1'b0, h_cnt} >= 13'(TILE_X0)) && ({1'b0, h_cnt} < 13'(TILE_X0 + TILE_SIZE)) &&
                       ({1'b0, v_cnt} >= 13'(TILE_Y0)) && ({1'b0, v_cnt} < 13'(TILE_Y0 + TILE_SIZE));
    assign w_n_raw   = digit_count(r_disp_state);
    assign w_n       = (int'(w_n_raw) > MAX_DIGITS) ? 3'(MAX_DIGITS) : w_n_raw;
    assign w_text_w  = 13'(w_n) * 13'(GLYPH_W);
    assign w_text_x0 = (13'(TILE_SIZE) - w_text_w) >> 1;
    assign w_tx      = w_hx - w_text_x0;
    assign w_ty      = w_ly - 13'(c_TEXT_Y0);
    assign w_in_text = w_in_tile &&
                       (w_hx >= w_text_x0) && (w_hx < w_text_x0 + w_text_w) &&
                       (w_ly >= 13'(c_TEXT_Y0)) && (w_ly < 13'(c_TEXT_Y0 + GLYPH_H));

    generate
        if ((GLYPH_W & (GLYPH_W - 1)) == 0) begin : g_pow2_cell
            assign w_dig_idx = 2'(w_tx >> c_COL_W);
            assign w_col     = c_COL_W'(w_tx);
        end else begin : g_div_cell
            assign w_dig_idx = 2'(w_tx / 13'(GLYPH_W));
            assign w_col     = c_COL_W'(w_tx % 13'(GLYPH_W));
        end
    endgenerate

    assign w_glyph = w_in_text ? state_glyph(r_disp_state, w_dig_idx) : c_GLYPH_BLANK;
    assign w_bg    = (r_pop_cnt != '0) ? POP_COLOR : bg_color(r_disp_state);

    logic               r1_in_tile;
    logic [3:0]         r1_glyph;
    logic [c_ROW_W-1:0] r1_row;
    logic [c_COL_W-1:0] r1_col;
    rgb444_t            r1_bg, r1_fg;

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_in_tile <= 1'b0;
            r1_glyph   <= c_GLYPH_BLANK;
            r1_row     <= '0;
            r1_col     <= '0;
            r1_bg      <= '0;
            r1_fg      <= '0;
        end else begin
            r1_in_tile <= w_in_tile;
            r1_glyph   <= w_glyph;
            r1_row     <= w_in_text ? c_ROW_W'(w_ty) : '0;
            r1_col     <= w_col;
            r1_bg      <= w_bg;
            r1_fg      <= font_color(r_disp_state);
        end
    end

    // Stage 2: glyph row fetch, side-band fields delayed alongside
    logic [GLYPH_W-1:0] w_rom_bits;

    font_rom #(
        .GLYPH_W (GLYPH_W),
        .GLYPH_H (GLYPH_H),
        .ROW_W   (c_ROW_W)
    ) u_font_rom (
        .clk   (clk),
        .rst   (rst),
        .digit (r1_glyph),
        .row   (r1_row),
        .bits  (w_rom_bits)
    );

    logic               r2_in_tile;
    logic [c_COL_W-1:0] r2_col;
    rgb444_t            r2_bg, r2_fg;

    always_ff @(posedge clk) begin
        if (rst) begin
            r2_in_tile <= 1'b0;
            r2_col     <= '0;
            r2_bg      <= '0;
            r2_fg      <= '0;
        end else begin
            r2_in_tile <= r1_in_tile;
            r2_col     <= r1_col;
            r2_bg      <= r1_bg;
            r2_fg      <= r1_fg;
        end
    end

    // Stage 3: colour mux
    logic    w_lit;
    rgb444_t r_vga_data;
    logic    r_in_tile;

    assign w_lit = w_rom_bits[c_COL_W'(GLYPH_W - 1) - r2_col];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vga_data <= '0;
            r_in_tile  <= 1'b0;
        end else begin
            r_in_tile  <= r2_in_tile;
            r_vga_data <= !r2_in_tile ? 12'h000 : (w_lit ? r2_fg : r2_bg);
        end
    end

    assign vga_data = r_vga_data;
    assign in_tile  = r_in_tile;

endmodule
`default_nettype wire

// File: tb/tb_tile_glyph_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tile_glyph_renderer
// Brief    : Directed self-checking bench for tile_glyph_renderer.
// Revision : 1.0
// ============================================================================
module tb_tile_glyph_renderer;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic [3:0]  state;
    logic [11:0] h_cnt, v_cnt;
    logic [11:0] vga_data;
    logic        in_tile;

    int checks = 0;
    int errors = 0;

    tile_glyph_renderer #(
        .TILE_X0    (0),
        .TILE_Y0    (0),
        .TILE_SIZE  (128),
        .GLYPH_W    (16),
        .GLYPH_H    (46),
        .MAX_DIGITS (4),
        .POP_FRAMES (4),
        .POP_COLOR  (12'hFFE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .state       (state),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .vga_data    (vga_data),
        .in_tile     (in_tile)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic px(input string tag, input int h, input int v,
                      input logic [11:0] exp_rgb, input logic exp_in);
        @(negedge clk);
        h_cnt = 12'(h);
        v_cnt = 12'(v);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_rgb"}, vga_data, exp_rgb);
        chk({tag, "_in"}, {11'b0, in_tile}, {11'b0, exp_in});
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            frame_start = 1'b1;
            @(negedge clk);
            frame_start = 1'b0;
        end
    endtask

    // Glyph probes for value 2048: text box x 32..95, y 41..86
    typedef struct {int h; int v; logic [11:0] rgb;} probe_t;
    probe_t probes[15] = '{
        '{37, 43, 12'hFFF},  // '2' top bar
        '{37, 42, 12'hFFF},  // '2' top bar, first lit row
        '{37, 40, 12'hEC2},  // above text box
        '{32, 43, 12'hEC2},  // glyph column 0 never lit
        '{34, 51, 12'hEC2},  // '2' has no upper-left stroke
        '{44, 51, 12'hFFF},  // '2' upper-right stroke
        '{34, 71, 12'hFFF},  // '2' lower-left stroke
        '{44, 71, 12'hEC2},  // '2' has no lower-right stroke
        '{39, 63, 12'hFFF},  // '2' middle bar
        '{39, 83, 12'hFFF},  // '2' bottom bar
        '{39, 86, 12'hEC2},  // last glyph row blank
        '{55, 63, 12'hEC2},  // '0' has no middle bar
        '{66, 43, 12'hFFF},  // '4' upper-left stroke
        '{82, 51, 12'hFFF},  // '8' upper-left stroke
        '{100, 43, 12'hEC2}  // right of text box
    };

    initial begin
        rst = 1'b1;
        frame_start = 1'b0;
        state = 4'd0;
        h_cnt = 12'd300;
        v_cnt = 12'd300;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rgb", vga_data, 12'h000);
        chk("reset_in", {11'b0, in_tile}, 12'h000);

        // Latency: out-of-tile history, then (5,5) must appear on the 3rd edge only
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        h_cnt = 12'd5;
        v_cnt = 12'd5;
        repeat (2) @(posedge clk);
        #1;
        chk("lat_early_in", {11'b0, in_tile}, 12'h000);
        @(posedge clk);
        #1;
        chk("lat_rgb", vga_data, 12'h000);
        chk("lat_in", {11'b0, in_tile}, 12'h001);

        // Value 2048 after its pop has expired
        state = 4'd11;
        frames(5);
        px("s11_bg", 10, 10, 12'hEC2, 1'b1);
        for (int i = 0; i < 15; i++)
            px($sformatf("glyph_%0d_%0d", probes[i].h, probes[i].v),
               probes[i].h, probes[i].v, probes[i].rgb, 1'b1);

        // Mid-frame change 1->2 is held until frame_start, then pops 4 frames
        state = 4'd1;
        frames(5);
        px("s1_bg", 10, 10, 12'hEED, 1'b1);
        state = 4'd2;
        px("s2_midframe", 10, 10, 12'hEED, 1'b1);
        for (int f = 1; f <= 5; f++) begin
            frames(1);
            px($sformatf("pop_f%0d", f), 10, 10, (f <= 4) ? 12'hFFE : 12'hEEC, 1'b1);
        end

        // Retrigger: 2->3 during pop frame 2 restarts the 4-frame pop
        state = 4'd1;
        frames(5);
        state = 4'd2;
        frames(1);
        px("retrig_p1", 10, 10, 12'hFFE, 1'b1);
        frames(1);
        px("retrig_p2", 10, 10, 12'hFFE, 1'b1);
        state = 4'd3;
        for (int f = 1; f <= 5; f++) begin
            frames(1);
            px($sformatf("retrig_f%0d", f), 10, 10, (f <= 4) ? 12'hFFE : 12'hFB7, 1'b1);
        end

        // Change to 0 cancels an active pop
        state = 4'd5;
        frames(1);
        px("s5_pop", 10, 10, 12'hFFE, 1'b1);
        state = 4'd0;
        frames(1);
        px("s0_clear", 10, 10, 12'h000, 1'b1);

        // Tile bounds
        px("out_h", 200, 10, 12'h000, 1'b0);
        px("out_v", 10, 128, 12'h000, 1'b0);
        px("out_edge_h", 128, 127, 12'h000, 1'b0);
        px("corner_in", 127, 127, 12'h000, 1'b1);

        // Invalid state: flat 333, no glyphs
        state = 4'd14;
        frames(5);
        px("s14_a", 10, 10, 12'h333, 1'b1);
        px("s14_b", 64, 64, 12'h333, 1'b1);
        px("s14_c", 37, 43, 12'h333, 1'b1);
        px("s14_d", 63, 63, 12'h333, 1'b1);

        // Reset mid-line with state 11 shown
        state = 4'd11;
        frames(5);
        px("pre_rst", 10, 10, 12'hEC2, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_rgb", vga_data, 12'h000);
        chk("mrst_in", {11'b0, in_tile}, 12'h000);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("refill_%0d_rgb", i), vga_data, 12'h000);
            chk($sformatf("refill_%0d_in", i), {11'b0, in_tile}, 12'h000);
        end
        @(posedge clk);
        #1;
        chk("refill_3_rgb", vga_data, 12'h000);
        chk("refill_3_in", {11'b0, in_tile}, 12'h001);
        px("post_rst_s0", 37, 43, 12'h000, 1'b1);
        frames(1);
        px("post_rst_pop", 10, 10, 12'hFFE, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tile_glyph_renderer.md
TILE_GLYPH_RENDERER -- requirements
Module: tile_glyph_renderer

Interface
REQ-001 SHALL have parameter TILE_X0, default 0: tile left pixel column.
REQ-002 SHALL have parameter TILE_Y0, default 0: tile top pixel row.
REQ-003 SHALL have parameter TILE_SIZE, default 128: tile edge length in pixels; must be at least MAX_DIGITS*GLYPH_W and at least GLYPH_H.
REQ-004 SHALL have parameter GLYPH_W, default 16, and parameter GLYPH_H, default 46: glyph cell size.
REQ-005 SHALL have parameter MAX_DIGITS, default 4: the widest decimal value shown.
REQ-006 SHALL have parameter POP_FRAMES, default 8: pop-highlight length in frames; 0 disables pop.
REQ-007 SHALL have parameter POP_COLOR, default 12'hFFE: pop background colour.
REQ-008 SHALL have port clk, input, 1 bit: the single clock.
REQ-009 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-010 SHALL have port frame_start, input, 1 bit: one-cycle pulse per frame, issued before the first visible pixel.
REQ-011 SHALL have port state, input, 4 bits: tile exponent code; 0 means empty, n means 2^n, 13-15 are invalid.
REQ-012 SHALL have ports h_cnt and v_cnt, input, 12 bits each: current pixel coordinate.
REQ-013 SHALL have port vga_data, output, 12 bits: RGB444 pixel.
REQ-014 SHALL have port in_tile, output, 1 bit: high when the output pixel lies inside the tile, aligned with vga_data.

Function
REQ-015 SHALL update the displayed state (disp_state) only on a frame_start cycle, by sampling state in that cycle; state changes mid-frame SHALL NOT affect the current frame.
REQ-016 SHALL produce vga_data and in_tile exactly 3 clocks after the h_cnt/v_cnt they describe, through three stages: coordinate decode, font_rom read, colour mux.
REQ-017 SHALL treat a pixel as inside the tile when TILE_X0 <= h_cnt < TILE_X0+TILE_SIZE and TILE_Y0 <= v_cnt < TILE_Y0+TILE_SIZE; outside pixels SHALL give vga_data=0 and in_tile=0.
REQ-018 SHALL set the digit count n from disp_state: 1 for 1-3, 2 for 4-6, 3 for 7-9, 4 for 10-12, 0 for 0 and 13-15; values of n above MAX_DIGITS SHALL be clamped to MAX_DIGITS, leftmost digits first.
REQ-019 SHALL centre the text: text_x0 = (TILE_SIZE - n*GLYPH_W)/2 and text_y0 = (TILE_SIZE - GLYPH_H)/2, relative to the tile, using integer division.
REQ-020 SHALL, inside the text box, select digit index = local_x_offset / GLYPH_W and glyph column c = local_x_offset mod GLYPH_W, with no division hardware when GLYPH_W is a power of two; the lit bit is font row bit [GLYPH_W-1-c].
REQ-021 SHALL use the background colour table: 0->000, 1->EED, 2->EEC, 3->FB7, 4->F96, 5->F75, 6->F53, 7->ED7, 8->EC6, 9->EC5, 10->EC3, 11->EC2, 12->EC1, 13-15->333.
REQ-022 SHALL use font colour 766 for states 1-2 and FFF otherwise; a lit glyph pixel outputs the font colour, any other in-tile pixel outputs the background colour (or POP_COLOR while popping).
REQ-023 SHALL, at frame_start, load pop_cnt=POP_FRAMES when the sampled state differs from disp_state and is nonzero; otherwise it SHALL decrement pop_cnt if it is nonzero; a pop is active while pop_cnt != 0.
REQ-024 SHALL, on a new qualifying change during an active pop, reload pop_cnt (retrigger); a change to state 0 SHALL clear pop_cnt immediately.

Reset
REQ-025 SHALL, while rst=1 at a clk edge, clear disp_state, pop_cnt, all pipeline registers, vga_data and in_tile to 0.
REQ-026 SHALL, when reset is asserted mid-frame, output 0 until the pipeline refills; the first valid pixel appears 3 clocks after rst falls, and the tile shows state 0 until the next frame_start.

Structure
REQ-027 SHALL place the colour tables, the state-to-decimal-digit table (glyph 15 = blank) and the digit-count function in the shared package tile_gfx_pkg.
REQ-028 SHALL instantiate the existing font_rom (1-cycle registered read, index = digit, row = v offset) as its only sub-module.

Verification (TILE_X0=TILE_Y0=0, TILE_SIZE=128, GLYPH_W=16, GLYPH_H=46, POP_FRAMES=4)
REQ-029 SHALL cover: rst high then low, pixel (5,5) -> vga_data=000 and in_tile=1 exactly 3 clocks later.
REQ-030 SHALL cover: state=11 plus frame_start, pixel (10,10) -> EC2; text_x0=32, text_y0=41; pixel (32+c,41+r) -> FFF where "2" glyph row r bit [15-c] is set.
REQ-031 SHALL cover: state changes 1->2 mid-frame -> pixel (10,10) stays EED until the next frame_start, then shows POP_COLOR for 4 frames, then EEC.
REQ-032 SHALL cover: a second change during a pop (2->3 at pop frame 2) -> POP_COLOR for 4 more frames, then FB7.
REQ-033 SHALL cover: pixel (200,10) or (10,128) -> vga_data=0 and in_tile=0; state=14 -> 333 over the whole tile with no glyph pixels.
REQ-034 SHALL cover: rst pulsed mid-line with state=11 -> output 0 for 3 clocks, then 000 in-tile until the next frame_start.
